// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge (dmem_bridge).
package dmem_bridge_pkg;

    localparam int unsigned REG_BUS_W  = 32;
    localparam int unsigned ADDR_BUS_W = 32;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } dmem_state_e;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Watchdog counter for an outstanding bus transaction; flags expiry on the
// LIMIT-th consecutive un-acked BUSY cycle.
module dmem_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_c
);

    localparam int unsigned RAW_W = $clog2(LIMIT + 1);
    localparam int unsigned CNT_W = (RAW_W < 8) ? 8 : RAW_W;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current cycle is the LIMIT-th wait cycle when LIMIT-1 have already elapsed.
    assign expire_c = inc_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle data-RAM port onto a registered req/ack bus,
// stalling the pipeline while a transaction is outstanding.
// Optional watchdog abort is enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_BUS_W,
    parameter int unsigned DATA_W = REG_BUS_W
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_ce_i,
    input  logic                  ram_we_i,
    input  logic [DATA_W/8-1:0]   ram_sel_i,
    input  logic [ADDR_W-1:0]     ram_addr_i,
    input  logic [DATA_W-1:0]     ram_data_i,
    output logic [DATA_W-1:0]     ram_data_o,
    output logic                  stallreq_from_mem,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic [DATA_W-1:0]     bus_rdata_i
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    ,
    output logic                  bus_err_o
`endif
);

    localparam int unsigned SEL_W = DATA_W / 8;

    dmem_state_e         state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                stall_c;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic err_q, err_d;
    logic expire_c;

    dmem_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .clr_i    ((state_q == ST_IDLE) && (ram_ce_i == CHIP_ENABLE)),
        .inc_i    ((state_q == ST_BUSY) && !bus_ack_i),
        .expire_c (expire_c)
    );

    assign bus_err_o = err_q;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stall_c = 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (ram_ce_i == CHIP_ENABLE) begin
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    we_d    = ram_we_i;
                    sel_d   = ram_sel_i;
                    addr_d  = ram_addr_i;
                    wdata_d = ram_data_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                if (bus_ack_i) begin
                    req_d   = 1'b0;
                    rdata_d = (we_q == WRITE_ENABLE) ? '0 : bus_rdata_i;
                    state_d = ST_DONE;
                end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                else if (expire_c) begin
                    req_d   = 1'b0;
                    rdata_d = DATA_W'(DMEM_ERR_DATA);
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            // Single release cycle; ce is deliberately ignored so the access is not re-issued.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Stall is combinational so the issue cycle itself is frozen; forced low during reset.
    assign stallreq_from_mem = stall_c & rst;

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_sel_o   = sel_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign ram_data_o  = rdata_q;

endmodule
